// File: rtl/chip_intf_bridge_rx.sv
// Receive side of the chip outbound link: per-channel beat FIFOs, flit pairing, credit return.
// Optional CHIP_INTF_RX_STATS_EN adds saturating per-channel accepted-beat counters on beat_cnt.
module chip_intf_bridge_rx #(
  parameter int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic        io_clk,
  input  logic        rst,
  input  logic [31:0] chip_intf_data,
  input  logic [1:0]  chip_intf_channel,
  output logic [2:0]  chip_intf_credit_back,
  output logic [63:0] noc1_data,
  output logic        noc1_valid,
  input  logic        noc1_ready,
  output logic [63:0] noc2_data,
  output logic        noc2_valid,
  input  logic        noc2_ready,
  output logic [63:0] noc3_data,
  output logic        noc3_valid,
  input  logic        noc3_ready,
`ifdef CHIP_INTF_RX_STATS_EN
  output logic [47:0] beat_cnt,
`endif
  output logic [2:0]  overflow_err
);

  logic [31:0]      mem    [3][DEPTH];
  logic [PTR_W-1:0] wr_ptr [3];
  logic [PTR_W-1:0] rd_ptr [3];
  logic [PTR_W-1:0] rd_nx  [3];
  logic [CNT_W-1:0] occ    [3];
  logic [CNT_W-1:0] pend   [3];
  logic [63:0]      flit   [3];
  logic [2:0]       err;
  logic [2:0]       vld;
  logic [2:0]       rdy;
  logic [2:0]       push;
  logic [2:0]       pop;
  logic [2:0]       accept;
  logic [2:0]       credit;

  assign rdy = {noc3_ready, noc2_ready, noc1_ready};

  // Per-channel handshake decode; a pop frees room before the push is judged
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      vld[k]    = occ[k] >= CNT_W'(2);
      pop[k]    = vld[k] & rdy[k];
      push[k]   = chip_intf_channel == 2'(k + 1);
      accept[k] = push[k] &&
                  (occ[k] != CNT_W'(DEPTH) || pop[k]);
      rd_nx[k]  = rd_ptr[k] + PTR_W'(1);
      credit[k] = pend[k] != '0;
      flit[k]   = vld[k] ?
                  {mem[k][rd_nx[k]], mem[k][rd_ptr[k]]} :
                  64'h0;
    end
  end

  // FIFO pointers, occupancy, pending credits and sticky overflow flags
  always_ff @(posedge io_clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        occ[k]    <= '0;
        pend[k]   <= '0;
      end
      err <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (pop[k])
          rd_ptr[k] <= rd_ptr[k] + PTR_W'(2);
        if (accept[k]) begin
          mem[k][wr_ptr[k]] <= chip_intf_data;
          wr_ptr[k] <= wr_ptr[k] + PTR_W'(1);
        end
        if (push[k] && !accept[k])
          err[k] <= 1'b1;
        occ[k] <= occ[k]
                - (pop[k] ? CNT_W'(2) : CNT_W'(0))
                + CNT_W'(accept[k]);
        pend[k] <= pend[k]
                 + (pop[k] ? CNT_W'(2) : CNT_W'(0))
                 - CNT_W'(credit[k]);
      end
    end
  end

`ifdef CHIP_INTF_RX_STATS_EN
  logic [15:0] cnt [3];

  // Saturating count of beats actually written into each FIFO
  always_ff @(posedge io_clk) begin
    if (rst) begin
      for (int k = 0; k < 3; k++)
        cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 3; k++)
        if (accept[k] && cnt[k] != 16'hFFFF)
          cnt[k] <= cnt[k] + 16'd1;
    end
  end

  assign beat_cnt = {cnt[2], cnt[1], cnt[0]};
`endif

  assign chip_intf_credit_back = credit;
  assign overflow_err          = err;
  assign noc1_valid            = vld[0];
  assign noc2_valid            = vld[1];
  assign noc3_valid            = vld[2];
  assign noc1_data             = flit[0];
  assign noc2_data             = flit[1];
  assign noc3_data             = flit[2];

endmodule
